// File: rtl/melody_pkg.sv
// Shared types, entry layout and note codes for the melody sequencer.
package melody_pkg;

  localparam int unsigned NOTE_W  = 3;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned DUR_W   = 2;
  localparam int unsigned ENTRY_W = 6;

  // Song entry layout: [5] rest, [4:3] duration code, [2:0] note
  localparam int unsigned REST_BIT = 5;
  localparam int unsigned DUR_MSB  = 4;
  localparam int unsigned DUR_LSB  = 3;
  localparam int unsigned NOTE_MSB = 2;
  localparam int unsigned NOTE_LSB = 0;

  localparam logic [NOTE_W-1:0] NOTE_C3 = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_D3 = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_E3 = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_F3 = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_G3 = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_A3 = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_B3 = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_C4 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Build a table entry; dur is the duration code (beats - 1)
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic rest,
                                                  input logic [DUR_W-1:0] dur,
                                                  input logic [NOTE_W-1:0] note);
    logic [ENTRY_W-1:0] e;
    e                    = '0;
    e[REST_BIT]          = rest;
    e[DUR_MSB:DUR_LSB]   = dur;
    e[NOTE_MSB:NOTE_LSB] = note;
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a host and the melody sequencer.
interface melody_sequencer_if;
  import melody_pkg::*;

  logic              start;
  logic              stop;
  logic [NOTE_W-1:0] note;
  logic              enable;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step;

  modport master (output start, stop, input note, enable, busy, done, step);
  modport slave  (input start, stop, output note, enable, busy, done, step);
endinterface

// File: rtl/melody_rom.sv
// Combinational song table; addresses past the song length read as 1-beat rests.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned SONG_LEN = 16
) (
  input  logic [STEP_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] entry_c_o
);

  // Table lookup with rest fill beyond the active song
  always_comb begin
    entry_c_o = mk_entry(1'b1, 2'd0, NOTE_C3);
    if (32'(addr_i) < SONG_LEN) begin
      case (addr_i)
        4'd0:    entry_c_o = mk_entry(1'b0, 2'd0, NOTE_C3);
        4'd1:    entry_c_o = mk_entry(1'b0, 2'd1, NOTE_D3);
        4'd2:    entry_c_o = mk_entry(1'b1, 2'd0, NOTE_C3);
        4'd3:    entry_c_o = mk_entry(1'b0, 2'd3, NOTE_C4);
        4'd4:    entry_c_o = mk_entry(1'b0, 2'd0, NOTE_E3);
        4'd5:    entry_c_o = mk_entry(1'b0, 2'd0, NOTE_F3);
        4'd6:    entry_c_o = mk_entry(1'b0, 2'd1, NOTE_G3);
        4'd7:    entry_c_o = mk_entry(1'b0, 2'd0, NOTE_A3);
        4'd8:    entry_c_o = mk_entry(1'b0, 2'd0, NOTE_G3);
        4'd9:    entry_c_o = mk_entry(1'b1, 2'd1, NOTE_C3);
        4'd10:   entry_c_o = mk_entry(1'b0, 2'd0, NOTE_B3);
        4'd11:   entry_c_o = mk_entry(1'b0, 2'd1, NOTE_C4);
        4'd12:   entry_c_o = mk_entry(1'b0, 2'd0, NOTE_G3);
        4'd13:   entry_c_o = mk_entry(1'b0, 2'd0, NOTE_E3);
        4'd14:   entry_c_o = mk_entry(1'b0, 2'd3, NOTE_C3);
        default: entry_c_o = mk_entry(1'b1, 2'd0, NOTE_C3);
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays a fixed song table as note/enable pairs with exact per-entry timing.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned SONG_LEN    = 16,
  parameter int unsigned BEAT_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES  = 20000,
  parameter int unsigned LOOP        = 0
) (
  input  logic               clk_1MHz,
  input  logic               rst_n,
  melody_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(4 * BEAT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               rest_q, rest_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [STEP_W-1:0]  rom_addr_c;
  logic [ENTRY_W-1:0] entry_c;
  logic [31:0]        entry_len_c;
  logic               play_end_c;
  logic               entry_end_c;
  logic               last_step_c;

  // The ROM is always addressed at the entry that would be loaded next
  melody_rom #(.SONG_LEN(SONG_LEN)) u_rom (
    .addr_i    (rom_addr_c),
    .entry_c_o (entry_c)
  );

  // Entry timing and next-entry address
  always_comb begin
    last_step_c = (step_q == STEP_W'(SONG_LEN - 1));
    rom_addr_c  = (state_q == ST_IDLE || last_step_c) ? '0 : step_q + STEP_W'(1);
    entry_len_c = (32'(dur_q) + 32'd1) * BEAT_CYCLES;
    play_end_c  = (32'(cnt_q) == entry_len_c - GAP_CYCLES - 32'd1);
    entry_end_c = (32'(cnt_q) == entry_len_c - 32'd1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    note_d   = note_q;
    dur_d    = dur_q;
    rest_d   = rest_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = ST_PLAY;
          step_d   = '0;
          cnt_d    = '0;
          note_d   = entry_c[NOTE_MSB:NOTE_LSB];
          dur_d    = entry_c[DUR_MSB:DUR_LSB];
          rest_d   = entry_c[REST_BIT];
          enable_d = !entry_c[REST_BIT];
          busy_d   = 1'b1;
        end
      end

      ST_PLAY: begin
        if (bus.stop) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (play_end_c) begin
            state_d  = ST_GAP;
            enable_d = 1'b0;
          end
        end
      end

      ST_GAP: begin
        if (bus.stop) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (entry_end_c) begin
          if (!last_step_c || LOOP != 0) begin
            state_d  = ST_PLAY;
            step_d   = last_step_c ? '0 : step_q + STEP_W'(1);
            cnt_d    = '0;
            note_d   = entry_c[NOTE_MSB:NOTE_LSB];
            dur_d    = entry_c[DUR_MSB:DUR_LSB];
            rest_d   = entry_c[REST_BIT];
            enable_d = !entry_c[REST_BIT];
          end else begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      note_q   <= '0;
      dur_q    <= '0;
      rest_q   <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      rest_q   <= rest_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.note   = note_q;
  assign bus.step   = step_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a short 4-entry song.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int unsigned BEAT = 10;
  localparam int unsigned GAP  = 2;
  localparam int unsigned LEN  = 4;

  logic clk_1MHz = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  melody_sequencer_if bus();
  melody_sequencer_if bus_loop();

  always #5 clk_1MHz = ~clk_1MHz;

  melody_sequencer #(.SONG_LEN(LEN), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .LOOP(0)) dut (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  melody_sequencer #(.SONG_LEN(LEN), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .LOOP(1)) dut_loop (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .bus      (bus_loop)
  );

  // Observed vector layout: {note[2:0], step[3:0], enable, busy, done}
  function automatic logic [9:0] pack(input logic [2:0] n, input logic [3:0] s,
                                      input logic e, input logic b, input logic d);
    return {n, s, e, b, d};
  endfunction

  task automatic tick();
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus_loop.start = 1'b0; bus_loop.stop = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== 10'h000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, 10'h000);
    end
    got = pack(bus_loop.note, bus_loop.step, bus_loop.enable, bus_loop.busy, bus_loop.done);
    checks++;
    if (got !== 10'h000) begin
      failures++;
      $display("FAIL reset_state_loop got=%h exp=%h", got, 10'h000);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Full song; optionally re-pulses start mid-entry-1, which must be ignored
  task automatic test_song_timing(input bit repulse);
    logic [9:0] got, exp;
    logic [2:0] en_note;
    logic [3:0] en_step;
    logic       en;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 84; c++) begin
      en      = (c <= 7) || (c >= 10 && c <= 27) || (c >= 40 && c <= 77);
      en_note = (c < 10) ? 3'd0 : (c < 30) ? 3'd1 : (c < 40) ? 3'd0 : 3'd7;
      en_step = (c < 10) ? 4'd0 : (c < 30) ? 4'd1 : (c < 40) ? 4'd2 : 4'd3;
      exp = pack(en_note, en_step, en, (c < 80), (c == 80));
      got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL song_timing repulse=%0d cycle=%0d got=%h exp=%h", repulse, c, got, exp);
      end
      bus.start = (repulse && c == 15);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_loop();
    logic [9:0] got;
    bus_loop.start = 1'b1;
    tick();
    bus_loop.start = 1'b0;
    for (int c = 0; c < 86; c++) begin
      got = pack(bus_loop.note, bus_loop.step, bus_loop.enable, bus_loop.busy, bus_loop.done);
      checks++;
      if (bus_loop.done !== 1'b0 || bus_loop.busy !== 1'b1) begin
        failures++;
        $display("FAIL loop_no_done cycle=%0d got=%h", c, got);
      end
      if (c == 79) begin
        checks++;
        if (got !== pack(3'd7, 4'd3, 1'b0, 1'b1, 1'b0)) begin
          failures++;
          $display("FAIL loop_last_gap got=%h exp=%h", got, pack(3'd7, 4'd3, 1'b0, 1'b1, 1'b0));
        end
      end
      if (c == 80) begin
        checks++;
        if (got !== pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0)) begin
          failures++;
          $display("FAIL loop_wrap got=%h exp=%h", got, pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0));
        end
      end
      tick();
    end
    bus_loop.stop = 1'b1;
    tick();
    bus_loop.stop = 1'b0;
    got = pack(bus_loop.note, bus_loop.step, bus_loop.enable, bus_loop.busy, bus_loop.done);
    checks++;
    if (got !== pack(3'd0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL loop_stop got=%h exp=%h", got, pack(3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_stop();
    logic [9:0] got;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== pack(3'd1, 4'd1, 1'b1, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL stop_pre got=%h exp=%h", got, pack(3'd1, 4'd1, 1'b1, 1'b1, 1'b0));
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
      checks++;
      if (got !== pack(3'd1, 4'd1, 1'b0, 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL stop_idle cycle=%0d got=%h exp=%h", c, got, pack(3'd1, 4'd1, 1'b0, 1'b0, 1'b0));
      end
      tick();
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL stop_restart got=%h exp=%h", got, pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0));
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
  endtask

  task automatic test_start_stop_idle();
    logic [9:0] got;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
      checks++;
      if (got[2:0] !== 3'b000) begin
        failures++;
        $display("FAIL start_stop_idle cycle=%0d got=%h", c, got);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [9:0] got;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== pack(3'd0, 4'd0, 1'b0, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL rst_gap_pre got=%h exp=%h", got, pack(3'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    end
    #3 rst_n = 1'b0;
    #1;
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== 10'h000) begin
      failures++;
      $display("FAIL rst_gap_async got=%h exp=%h", got, 10'h000);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
      checks++;
      if (got !== 10'h000) begin
        failures++;
        $display("FAIL rst_gap_quiet cycle=%0d got=%h exp=%h", c, got, 10'h000);
      end
      tick();
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got = pack(bus.note, bus.step, bus.enable, bus.busy, bus.done);
    checks++;
    if (got !== pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL rst_gap_restart got=%h exp=%h", got, pack(3'd0, 4'd0, 1'b1, 1'b1, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_song_timing(1'b0);
    tick();
    test_loop();
    test_stop();
    test_song_timing(1'b1);
    tick();
    test_start_stop_idle();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
